dsp_byte_spi_tx: RTL and testbench

DSP_BYTE_SPI_TX -- requirements
Module: dsp_byte_spi_tx

---
 rtl/dsp_spi_pkg.sv | 33 +++
 rtl/dsp_spi_halfper_cnt.sv | 35 +++
 rtl/dsp_byte_spi_tx.sv | 141 ++++++++++++++
 tb/tb_dsp_byte_spi_tx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dsp_spi_pkg.sv
// ============================================================================
// Module  : dsp_spi_pkg
// Brief   : Shared FSM states, SPI mode constants and bit-order helpers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dsp_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_HOLD     = 3'd4,
        ST_GAP      = 3'd5
    } spi_state_e;

    localparam logic c_CPOL      = 1'b0;
    localparam logic c_CPHA      = 1'b0;
    localparam logic c_MSB_FIRST = 1'b1;

    function automatic logic first_bit(input logic [7:0] b);
        return c_MSB_FIRST ? b[7] : b[0];
    endfunction

    function automatic logic [7:0] shift_out(input logic [7:0] b);
        return c_MSB_FIRST ? {b[6:0], 1'b0} : {1'b0, b[7:1]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/dsp_spi_halfper_cnt.sv
// ============================================================================
// Module  : dsp_spi_halfper_cnt
// Brief   : Reloadable down-counter; o_tick marks the last cycle of a phase.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_spi_halfper_cnt #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_load,
    output logic o_tick
);

    localparam logic [7:0] c_RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_RELOAD;
        end else if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_tick = (r_cnt == 8'd0);

endmodule

`default_nettype wire

// File: rtl/dsp_byte_spi_tx.sv
// ============================================================================
// Module  : dsp_byte_spi_tx
// Brief   : Sends the PIO byte over SPI mode 0 whenever it changes or on request.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_byte_spi_tx
    import dsp_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       byte_in,
    input  logic             send_req,
    output logic             spi_sclk,
    output logic             spi_mosi,
    output logic             spi_cs_n,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frame_cnt
);

    spi_state_e       r_state;
    spi_state_e       w_state_nxt;
    logic             r_launch;
    logic             r_pending;
    logic [7:0]       r_last_sent;
    logic [7:0]       r_shreg;
    logic [2:0]       r_bit;
    logic             r_sclk;
    logic             r_mosi;
    logic             r_cs_n;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             w_tick;
    logic             w_load;
    logic             w_trigger;
    logic             w_start;
    logic [7:0]       w_shifted;

    assign w_trigger = (byte_in != r_last_sent) || send_req || r_pending;
    // r_launch is the one IDLE cycle with cs_n already low before SETUP
    assign w_start   = (r_state == ST_IDLE) && !r_launch && w_trigger;
    assign w_shifted = shift_out(r_shreg);

    dsp_spi_halfper_cnt #(
        .CLK_DIV (CLK_DIV)
    ) u_halfper (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_load),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (r_launch) w_state_nxt = ST_SETUP;
            ST_SETUP:    if (w_tick)   w_state_nxt = ST_SHIFT_HI;
            ST_SHIFT_HI: if (w_tick)   w_state_nxt = (r_bit == 3'd7) ? ST_HOLD : ST_SHIFT_LO;
            ST_SHIFT_LO: if (w_tick)   w_state_nxt = ST_SHIFT_HI;
            ST_HOLD:     if (w_tick)   w_state_nxt = ST_GAP;
            ST_GAP:      if (w_tick)   w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
        w_load = (w_state_nxt != r_state);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_launch    <= 1'b0;
            r_pending   <= 1'b0;
            r_last_sent <= 8'h00;
            r_shreg     <= 8'h00;
            r_bit       <= 3'd0;
            r_sclk      <= c_CPOL;
            r_mosi      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            r_sclk <= (w_state_nxt == ST_SHIFT_HI) ? ~c_CPOL : c_CPOL;

            if (w_start) begin
                r_launch    <= 1'b1;
                r_pending   <= 1'b0;
                r_shreg     <= byte_in;
                r_last_sent <= byte_in;
                r_mosi      <= c_CPHA ? 1'b0 : first_bit(byte_in);
                r_bit       <= 3'd0;
                r_cs_n      <= 1'b0;
                r_busy      <= 1'b1;
            end else begin
                r_launch <= 1'b0;
                if (send_req) r_pending <= 1'b1;
            end

            // Next bit is presented on the first SHIFT_LO cycle
            if (r_state == ST_SHIFT_HI && w_tick && r_bit != 3'd7) begin
                r_shreg <= w_shifted;
                r_mosi  <= first_bit(w_shifted);
                r_bit   <= r_bit + 3'd1;
            end

            if (r_state == ST_HOLD && w_tick) begin
                r_cs_n      <= 1'b1;
                r_mosi      <= 1'b0;
                r_done      <= 1'b1;
                r_frame_cnt <= r_frame_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            if (r_state == ST_GAP && w_tick) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign spi_sclk  = r_sclk;
    assign spi_mosi  = r_mosi;
    assign spi_cs_n  = r_cs_n;
    assign busy      = r_busy;
    assign done      = r_done;
    assign frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dsp_byte_spi_tx.sv
// ============================================================================
// Module  : tb_dsp_byte_spi_tx
// Brief   : Directed self-checking bench for dsp_byte_spi_tx with CLK_DIV=2.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsp_byte_spi_tx;

    logic        clk;
    logic        reset_n;
    logic [7:0]  byte_in;
    logic        send_req;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic        busy;
    logic        done;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    int         cs_low_cnt = 0;
    int         done_cnt   = 0;
    int         rise_cnt   = 0;
    logic [7:0] rx         = 8'h00;

    dsp_byte_spi_tx #(
        .CLK_DIV (2),
        .CNT_W   (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .byte_in   (byte_in),
        .send_req  (send_req),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_cs_n  (spi_cs_n),
        .busy      (busy),
        .done      (done),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!spi_cs_n) cs_low_cnt++;
        if (done)      done_cnt++;
    end

    always @(posedge spi_sclk) begin
        rise_cnt++;
        rx = {rx[6:0], spi_mosi};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        cs_low_cnt = 0;
        done_cnt   = 0;
        rise_cnt   = 0;
        rx         = 8'h00;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_seen"}, {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        reset_n  = 1'b0;
        byte_in  = 8'h00;
        send_req = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cs_n",  {31'd0, spi_cs_n}, 32'd1);
        chk("rst_sclk",  {31'd0, spi_sclk}, 32'd0);
        chk("rst_mosi",  {31'd0, spi_mosi}, 32'd0);
        chk("rst_busy",  {31'd0, busy},     32'd0);
        chk("rst_done",  {31'd0, done},     32'd0);
        chk("rst_fcnt",  {16'd0, frame_cnt}, 32'd0);
        clr_mon();
        reset_n = 1'b1;

        // byte_in held at 0 after reset: no frame
        repeat (100) @(negedge clk);
        chk("idle0_cs_low", cs_low_cnt, 32'd0);
        chk("idle0_rises",  rise_cnt,   32'd0);
        chk("idle0_fcnt",   {16'd0, frame_cnt}, 32'd0);

        // 0x00 -> 0xA5: one full frame
        clr_mon();
        byte_in = 8'hA5;
        @(negedge clk);
        chk("a5_start_cs_n", {31'd0, spi_cs_n}, 32'd0);
        chk("a5_start_mosi", {31'd0, spi_mosi}, 32'd1);
        chk("a5_start_busy", {31'd0, busy},     32'd1);
        wait_done("a5");
        wait_idle("a5");
        chk("a5_rx",     {24'd0, rx}, 32'hA5);
        chk("a5_rises",  rise_cnt,    32'd8);
        chk("a5_cs_low", cs_low_cnt,  32'd35);
        chk("a5_dones",  done_cnt,    32'd1);
        chk("a5_fcnt",   {16'd0, frame_cnt}, 32'd1);
        chk("a5_sclk_idle", {31'd0, spi_sclk}, 32'd0);

        // 0x3C, then 0x11 and 0x22 mid-frame: 0x3C then 0x22 only
        clr_mon();
        byte_in = 8'h3C;
        repeat (10) @(negedge clk);
        byte_in = 8'h11;
        repeat (5) @(negedge clk);
        byte_in = 8'h22;
        wait_done("c3");
        chk("c3_rx", {24'd0, rx}, 32'h3C);
        wait_done("c22");
        wait_idle("c22");
        chk("c22_rx",    {24'd0, rx}, 32'h22);
        chk("c22_rises", rise_cnt,    32'd16);
        chk("c22_dones", done_cnt,    32'd2);
        chk("c22_fcnt",  {16'd0, frame_cnt}, 32'd3);
        repeat (30) @(negedge clk);
        chk("c22_no_more", done_cnt, 32'd2);

        // Steady 0x7E with send_req during GAP
        clr_mon();
        byte_in = 8'h7E;
        wait_done("7e_a");
        send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
        chk("7e_pending_set", {31'd0, dut.r_pending}, 32'd1);
        n = 1;
        while (spi_cs_n && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("7e_restart_lat", n, 32'd3);
        chk("7e_pending_clr", {31'd0, dut.r_pending}, 32'd0);
        wait_done("7e_b");
        wait_idle("7e_b");
        chk("7e_rx",    {24'd0, rx}, 32'h7E);
        chk("7e_dones", done_cnt,    32'd2);
        chk("7e_fcnt",  {16'd0, frame_cnt}, 32'd5);

        // Reset after the 3rd sclk rise aborts the frame
        clr_mon();
        byte_in = 8'h5A;
        n = 0;
        while (rise_cnt < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_rises", rise_cnt, 32'd3);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_cs_n", {31'd0, spi_cs_n}, 32'd1);
        chk("abort_sclk", {31'd0, spi_sclk}, 32'd0);
        chk("abort_busy", {31'd0, busy},     32'd0);
        repeat (3) @(negedge clk);
        chk("abort_dones", done_cnt, 32'd0);
        chk("abort_fcnt",  {16'd0, frame_cnt}, 32'd0);
        clr_mon();
        byte_in = 8'hA5;
        reset_n = 1'b1;
        wait_done("fresh");
        wait_idle("fresh");
        chk("fresh_rx",     {24'd0, rx}, 32'hA5);
        chk("fresh_rises",  rise_cnt,    32'd8);
        chk("fresh_cs_low", cs_low_cnt,  32'd35);
        chk("fresh_fcnt",   {16'd0, frame_cnt}, 32'd1);

        // frame_cnt wraps from all-ones to zero
        force dut.r_frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_frame_cnt;
        @(negedge clk);
        chk("wrap_pre", {16'd0, frame_cnt}, 32'hFFFF);
        clr_mon();
        send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
        wait_done("wrap");
        wait_idle("wrap");
        chk("wrap_fcnt", {16'd0, frame_cnt}, 32'd0);
        chk("wrap_rx",   {24'd0, rx}, 32'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
